// File: rtl/ram_ctrl.sv
// Single-port data RAM behind a valid/ready request channel and a held response channel.
// Latency: rsp_valid rises LATENCY cycles after the accept cycle; one transaction in flight.
// Backpressure: req_ready is low from accept until the cycle after the response handshake.
module ram_ctrl #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  // Byte lanes per word and the number of address bits that select a lane.
  localparam int NBE      = DATA_W / 8;
  localparam int OFF_W    = $clog2(NBE);
  // Width of the word index carved out of the byte address.
  localparam int IDX_W    = ADDR_W - OFF_W;
  // Bits needed to address the storage array (at least one).
  localparam int DEPTH_LG = $clog2(DEPTH);
  localparam int MEM_AW   = (DEPTH > 1) ? DEPTH_LG : 1;

  // Latency counter: LATENCY is at most 4, so three bits hold LATENCY-1.
  localparam int                CNT_W    = 3;
  localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(LATENCY - 1);

  // Controller states.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              rsp_done;
  logic              misaligned;
  logic              out_of_range;
  logic              acc_err;
  logic              wr_en;
  logic [IDX_W-1:0]  word_idx;
  logic [MEM_AW-1:0] mem_addr;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign word_idx = req_addr[ADDR_W-1:OFF_W];
  assign mem_addr = word_idx[MEM_AW-1:0];

  // Any nonzero lane-offset bit means the access does not start on a word boundary.
  generate
    if (OFF_W > 0) begin : g_off
      assign misaligned = |req_addr[OFF_W-1:0];
    end else begin : g_no_off
      assign misaligned = 1'b0;
    end
  endgenerate

  // DEPTH is a power of two, so index >= DEPTH exactly when any index bit at or
  // above log2(DEPTH) is set. This looks at the full index, so high addresses
  // never alias onto low words.
  generate
    if (IDX_W > DEPTH_LG) begin : g_range
      assign out_of_range = |word_idx[IDX_W-1:DEPTH_LG];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign acc_err = misaligned | out_of_range;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // Requests are only taken in IDLE and never while reset is asserted.
  assign req_ready = rst_n & (state == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state == S_RESP);
  assign rsp_done  = rsp_valid & rsp_ready;

  // An erroneous write must leave memory untouched.
  assign wr_en = accept & req_write & ~acc_err;

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // ---------------------------------------------------------------------------
  // Sequencing: IDLE -> (WAIT) -> RESP -> IDLE, WAIT only used for LATENCY > 1
  // ---------------------------------------------------------------------------
  // Advance the transaction state and count down the remaining latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (LATENCY > 1) begin
              state   <= S_WAIT;
              lat_cnt <= LAT_LOAD;
            end else begin
              state   <= S_RESP;
              lat_cnt <= '0;
            end
          end
        end
        S_WAIT: begin
          if (lat_cnt == CNT_W'(1)) begin
            state   <= S_RESP;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_done) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          lat_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // Byte-lane write, committed at the accept edge of an error-free write.
  // Storage is deliberately not reset so a write that was accepted before a
  // reset survives it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NBE; i++) begin
        if (req_be[i]) begin
          mem[mem_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response capture
  // ---------------------------------------------------------------------------
  // Snapshot the read word and error flag at the accept edge and hold them
  // until the response handshake. Reads see the pre-edge contents, which
  // already include every earlier committed write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q <= acc_err;
      if (req_write || acc_err) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= mem[mem_addr];
      end
    end else if (rsp_done) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: three instances with LATENCY 1, 2 and 3 share clock and reset.
// Directed vector table on the LATENCY=1 instance, random traffic against an
// array model on the LATENCY=2 instance, hand sequences for multi-cycle corners.
module tb_ram_ctrl;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_write [N];
  logic [31:0] req_addr  [N];
  logic [3:0]  req_be    [N];
  logic [31:0] req_wdata [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_err   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    ram_ctrl #(
      .DATA_W (32),
      .DEPTH  (64),
      .ADDR_W (32),
      .LATENCY(g + 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_be   (req_be[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // One full transaction on instance k: present request, wait for accept,
  // wait for the response, hold rsp_ready low for 'hold' cycles, then complete.
  task automatic run_txn(input int k, input bit wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input int hold,
                         input logic [31:0] exp_rd, input bit exp_err, input string tag);
    int          waits;
    int          lat;
    bit          busy_ok;
    bit          stable_ok;
    logic [31:0] rd0;
    logic        err0;
    @(negedge clk);
    req_write[k] = wr;
    req_addr[k]  = a;
    req_be[k]    = be;
    req_wdata[k] = wd;
    req_valid[k] = 1'b1;
    waits = 0;
    while (!req_ready[k] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready[k]) begin
      chk({tag, "_accept_timeout"}, 64'(req_ready[k]), 64'd1);
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // Scramble the request bus after the accept edge; it must be ignored.
    req_valid[k] = 1'b0;
    req_write[k] = 1'($urandom);
    req_addr[k]  = $urandom;
    req_be[k]    = 4'($urandom);
    req_wdata[k] = $urandom;
    lat     = 1;
    busy_ok = 1'b1;
    while (!rsp_valid[k] && lat < 12) begin
      if (req_ready[k]) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid[k]) begin
      chk({tag, "_rsp_timeout"}, 64'(rsp_valid[k]), 64'd1);
      return;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(k + 1));
    rd0  = rsp_rdata[k];
    err0 = rsp_err[k];
    chk({tag, "_rdata"}, 64'(rd0), 64'(exp_rd));
    chk({tag, "_err"}, 64'(err0), 64'(exp_err));
    stable_ok = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      if (!rsp_valid[k] || req_ready[k] || rsp_rdata[k] !== rd0 || rsp_err[k] !== err0)
        stable_ok = 1'b0;
      if (req_ready[k]) busy_ok = 1'b0;
      if (h < hold) @(negedge clk);
    end
    chk({tag, "_busy_rdy_low"}, 64'(busy_ok), 64'd1);
    if (hold > 0) chk({tag, "_held_stable"}, 64'(stable_ok), 64'd1);
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk({tag, "_post_valid"}, 64'(rsp_valid[k]), 64'd0);
    chk({tag, "_post_ready"}, 64'(req_ready[k]), 64'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t        vt [$];
  logic [31:0] model [64];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    bit          wr;
    bit          err;
    int          sel;
    int          wi;
    int          acc_cyc [$];
    logic [31:0] got [$];
    int          ri;
    bit          acc_prev;

    // Directed vectors for the LATENCY=1 instance.
    vt.push_back('{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0,        1'b0});
    vt.push_back('{1'b0, 32'h10,  4'h0, 32'h0,        32'hDEADBEEF, 1'b0});
    vt.push_back('{1'b1, 32'h10,  4'h5, 32'h11223344, 32'h0,        1'b0});
    vt.push_back('{1'b0, 32'h10,  4'hF, 32'h0,        32'hDE22BE44, 1'b0});
    vt.push_back('{1'b1, 32'h10,  4'h0, 32'hFFFFFFFF, 32'h0,        1'b0});
    vt.push_back('{1'b0, 32'h10,  4'h0, 32'h0,        32'hDE22BE44, 1'b0});
    vt.push_back('{1'b1, 32'h0,   4'hF, 32'h01020304, 32'h0,        1'b0});
    vt.push_back('{1'b0, 32'h100, 4'h0, 32'h0,        32'h0,        1'b1});
    vt.push_back('{1'b1, 32'h102, 4'hF, 32'hAAAAAAAA, 32'h0,        1'b1});
    vt.push_back('{1'b1, 32'h100, 4'hF, 32'h55555555, 32'h0,        1'b1});
    vt.push_back('{1'b0, 32'h0,   4'h0, 32'h0,        32'h01020304, 1'b0});
    vt.push_back('{1'b1, 32'hFC,  4'hF, 32'h0BADCAFE, 32'h0,        1'b0});
    vt.push_back('{1'b0, 32'hFC,  4'h0, 32'h0,        32'h0BADCAFE, 1'b0});
    vt.push_back('{1'b1, 32'h12,  4'hF, 32'h99999999, 32'h0,        1'b1});
    vt.push_back('{1'b0, 32'h12,  4'h0, 32'h0,        32'h0,        1'b1});
    vt.push_back('{1'b0, 32'h10,  4'h0, 32'h0,        32'hDE22BE44, 1'b0});
    vt.push_back('{1'b0, 32'hFFFFFFFC, 4'h0, 32'h0,   32'h0,        1'b1});

    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = '0;
      req_be[k]    = '0;
      req_wdata[k] = '0;
      rsp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Reset state.
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_rdy_%0d", k),   64'(req_ready[k]), 64'd0);
      chk($sformatf("rst_valid_%0d", k), 64'(rsp_valid[k]), 64'd0);
      chk($sformatf("rst_err_%0d", k),   64'(rsp_err[k]),   64'd0);
      chk($sformatf("rst_rdata_%0d", k), 64'(rsp_rdata[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++)
      chk($sformatf("idle_rdy_%0d", k), 64'(req_ready[k]), 64'd1);

    // Table-driven directed vectors.
    for (int v = 0; v < vt.size(); v++)
      run_txn(0, vt[v].wr, vt[v].addr, vt[v].be, vt[v].wdata, v % 3,
              vt[v].exp_rd, vt[v].exp_err, $sformatf("vec%0d", v));

    // Preload the LATENCY=2 instance so every word has a known value.
    for (int w = 0; w < 64; w++) begin
      model[w] = $urandom;
      run_txn(1, 1'b1, 32'(w * 4), 4'hF, model[w], 0, 32'h0, 1'b0, $sformatf("pre%0d", w));
    end

    // Random traffic against the array model.
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      wi  = $urandom_range(0, 63);
      if (sel < 7)       a = 32'(wi * 4);
      else if (sel < 9)  a = 32'(wi * 4 + $urandom_range(1, 3));
      else begin
        a = $urandom;
        if (a < 32'd256) a = a + 32'd256;
      end
      wr  = 1'($urandom);
      be  = 4'($urandom);
      wd  = $urandom;
      err = ((a % 4) != 0) || ((a / 4) >= 64);
      exp_rd = 32'h0;
      if (!err) begin
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) model[a / 4][8*b +: 8] = wd[8*b +: 8];
        end else begin
          exp_rd = model[a / 4];
        end
      end
      run_txn(1, wr, a, be, wd, $urandom_range(0, 2), exp_rd, err, $sformatf("rnd%0d", n));
    end

    // Back-to-back reads on LATENCY=2 with req_valid and rsp_ready held high.
    @(negedge clk);
    req_write[1] = 1'b0;
    req_addr[1]  = 32'(5 * 4);
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    ri = 0;
    acc_prev = 1'b0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      if (acc_prev) begin
        ri++;
        if (ri < 4) req_addr[1] = 32'((5 + ri) * 4);
        else        req_valid[1] = 1'b0;
      end
      if (rsp_valid[1]) got.push_back(rsp_rdata[1]);
      acc_prev = req_valid[1] && req_ready[1];
      if (acc_prev) acc_cyc.push_back(c);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b0;
    chk("b2b_accepts", 64'(acc_cyc.size()), 64'd4);
    chk("b2b_responses", 64'(got.size()), 64'd4);
    for (int j = 1; j < acc_cyc.size(); j++)
      chk($sformatf("b2b_spacing%0d", j), 64'(acc_cyc[j] - acc_cyc[j-1]), 64'd3);
    for (int j = 0; j < got.size(); j++)
      chk($sformatf("b2b_data%0d", j), 64'(got[j]), 64'(model[5 + j]));

    // LATENCY=3 with five cycles of response backpressure.
    run_txn(2, 1'b1, 32'h40, 4'hF, 32'h5A5AA5A5, 0, 32'h0, 1'b0, "bp_wr");
    run_txn(2, 1'b0, 32'h40, 4'h0, 32'h0, 5, 32'h5A5AA5A5, 1'b0, "bp_rd");

    // Reset while a write is in its latency window.
    @(negedge clk);
    req_write[2] = 1'b1;
    req_addr[2]  = 32'h20;
    req_be[2]    = 4'hF;
    req_wdata[2] = 32'hCAFEF00D;
    req_valid[2] = 1'b1;
    chk("mid_rst_accept_rdy", 64'(req_ready[2]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("mid_rst_in_wait", 64'(req_ready[2]), 64'd0);
    rst_n = 1'b0;
    chk("mid_rst_rdy_now", 64'(req_ready[2]), 64'd0);
    @(negedge clk);
    chk("mid_rst_valid_a", 64'(rsp_valid[2]), 64'd0);
    chk("mid_rst_rdy_a", 64'(req_ready[2]), 64'd0);
    @(negedge clk);
    chk("mid_rst_valid_b", 64'(rsp_valid[2]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(rsp_valid[2]), 64'd0);
    chk("post_rst_rdy", 64'(req_ready[2]), 64'd1);
    run_txn(2, 1'b0, 32'h20, 4'h0, 32'h0, 0, 32'hCAFEF00D, 1'b0, "post_rst_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
